fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: owns the program counter, fetches 32-bit instruction words from instruction memory over a request/acknowledge interface, and buffers up to two fetched words. It sits directly upstream of `control_unit`, which decodes `instr[31:26]`. It accepts branch/jump redirects resolved downstream, using the same `branch`/`offset` meaning that `control_unit` produces. The PC counts 32-bit words.

## Interface
- `RESET_PC`, 32'd0: word address fetched first after reset.
- `HALT_OP`, 6'd63: opcode (`instr[31:26]`) treated as halt. Used only with `FETCH_HALT_EN`.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset. Asynchronous and active-low.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: word address. Held stable while `imem_req`=1 and `imem_ack`=0.
- `imem_ack` input 1: transfer completes in a cycle where `imem_req` && `imem_ack`.
- `imem_rdata` input 32: instruction word, valid in the ack cycle.
- `instr_valid` output 1: buffer head is valid.
- `instr` output 32: buffer head word, fed to `control_unit.instruction`.
- `instr_pc` output 32: word address of `instr`.
- `instr_ready` input 1: consumer takes the head when `instr_valid` && `instr_ready`.
- `redirect` input 1: single-cycle pulse when a branch or jump is taken.
- `redirect_abs` input 1: 1 means the target is `redirect_offset` (jr-style). 0 means PC-relative.
- `redirect_offset` input 32: jump offset, or absolute target.
- `redirect_pc` input 32: `instr_pc` of the branching instruction.
- `halted` output 1: fetch stopped on `HALT_OP`.

## Operation
- Target computation: `redirect_abs ? redirect_offset : redirect_pc + redirect_offset`. The add is 32-bit and wraps modulo 2^32.
- States:
  - RUN: issuing or holding a request.
  - DROP: the request in flight must be discarded.
  - HALT: no requests issued.
- Buffer: 2-entry FIFO of {word, pc}. Count is 0..2.
- `imem_req` = (state≠HALT) && (count<2 || dequeue this cycle). In DROP, `imem_req` stays 1 until ack.
- On a RUN ack: enqueue {`imem_rdata`, pc}, then pc ← pc+1. 32'hFFFF_FFFF wraps to 0.
- An enqueue and a dequeue in the same cycle leave count unchanged.
- Redirect handling:
  - The FIFO is flushed (count←0). This takes priority over a same-cycle enqueue or dequeue.
  - If `imem_req`=1 without ack that cycle: latch the target and go to DROP. On the ack, discard the data, set pc←target, go to RUN.
  - Otherwise, including an ack in the same cycle, whose data is discarded: pc←target and stay in/return to RUN.
  - A redirect while in DROP overwrites the latched target.
- Halt: described under Configuration.
- Reset, asynchronous, outputs 0 unless stated:
  - pc=`RESET_PC`, state=RUN, FIFO empty.
  - `instr_valid`=0, `halted`=0, `instr`=0, `instr_pc`=0.
  - `imem_addr`=`RESET_PC`. `imem_req` follows the rule above, so it is 1 from the first cycle after release.
  - Reset asserted mid-transfer abandons it. Memory is required to accept a new request afterwards.

## Timing
- Zero-wait memory (ack same cycle): first `instr_valid` 1 cycle after the first request. Throughput is 1 word/cycle while `instr_ready`=1.
- N wait cycles: word appears N+1 cycles after `imem_req` rises.
- Redirect at cycle t with no request pending: `imem_addr`=target at t+1. Next valid instruction at t+2 with zero-wait memory.
- Redirect at cycle t while stalled: the target request starts the cycle after the stalled ack.
- `instr`/`instr_pc` stay stable while `instr_valid`=1 and `instr_ready`=0.
- `instr_valid`=0 in the cycle after a redirect.

## Configuration
- `FETCH_HALT_EN` defined:
  - Enqueuing a word with `[31:26]`==`HALT_OP` moves state to HALT after that enqueue. `halted`=1 from the next cycle.
  - `imem_req`=0 while in HALT. The halt word is still delivered downstream.
  - A redirect leaves HALT and clears `halted`. Reset also clears it.
- `FETCH_HALT_EN` not defined: no halt detection, `HALT_OP` is ignored, and `halted` is tied to 0.

## Test plan
- Reset release, `RESET_PC`=0x10, zero-wait memory, `instr_ready`=1: addresses 0x10, 0x11, 0x12 on consecutive cycles. `instr_pc` sequence 0x10, 0x11, 0x12 with no bubbles.
- `instr_ready`=0 for 5 cycles: 2 words buffered, `imem_req`=0, head held. On release, words come out in order with none lost.
- 3-wait-cycle memory, `redirect` (abs=0, `redirect_pc`=0x20, offset=0x8) during wait: the acked word is dropped, next `imem_addr`=0x28, and the first delivered `instr_pc`=0x28.
- `redirect` with abs=1, offset=0x100, coinciding with an ack and a dequeue: FIFO empty next cycle, ack data not delivered, next address 0x100.
- pc=0xFFFFFFFF: the next fetch address is 0x0.
- With `FETCH_HALT_EN`: word 0xFC000000 at 0x5 is delivered, `halted`=1, and no further `imem_req`. A redirect to 0x0 resumes fetch at 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the word-addressed PC, fetches
// over a req/ack memory interface into a 2-entry {word, pc} buffer, and
// applies taken branch/jump redirects resolved downstream.
// Optional feature macro: FETCH_HALT_EN (stop fetching after a HALT_OP word).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [5:0]  HALT_OP  = 6'd63
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic        redirect_abs,
  input  logic [31:0] redirect_offset,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DROP = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] word_q [2];
  logic [31:0] wpc_q  [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        deq;
  logic        xfer;
  logic        enq;
  logic        wr_ptr;
  logic        halt_hit;
  logic        stalled;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_abs ? redirect_offset : redirect_pc + redirect_offset;
  assign instr_valid     = (count_q != 2'd0);
  assign deq             = instr_valid && instr_ready;
  assign xfer            = imem_req && imem_ack;
  // A word is kept only on a RUN-state ack that is not flushed by a redirect.
  assign enq             = xfer && (state_q == S_RUN) && !redirect;
  // A request waiting on memory: its address must not move until the ack.
  assign stalled         = imem_req && !imem_ack;
  assign wr_ptr          = rd_ptr_q ^ count_q[0];
  assign instr           = word_q[rd_ptr_q];
  assign instr_pc        = wpc_q[rd_ptr_q];

`ifdef FETCH_HALT_EN
  assign halt_hit = enq && (imem_rdata[31:26] == HALT_OP);
`else
  logic unused_halt_op;
  assign halt_hit       = 1'b0;
  assign unused_halt_op = ^HALT_OP;
`endif

  // State register: FSM state, PC, latched redirect target, buffer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      target_q <= 32'd0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic: redirects win; a stalled request forces a DROP.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d  = state_q;
    target_d = target_q;
    if (redirect) begin
      if (stalled) begin
        state_d  = S_DROP;
        target_d = redirect_target;
      end else begin
        state_d  = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN:   if (halt_hit) state_d = S_HALT;
        S_DROP:  if (xfer) state_d = S_RUN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RUN;
      endcase
    end
  end

  // PC update: redirect target, deferred target after a dropped ack, or +1.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      if (!stalled) pc_d = redirect_target;
    end else if (state_q == S_DROP) begin
      if (xfer) pc_d = target_q;
    end else if (enq) begin
      pc_d = pc_q + 32'd1;
    end
  end

  // Buffer occupancy: flush on redirect, otherwise enqueue/dequeue bookkeeping.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end else begin
      if (deq) rd_ptr_d = ~rd_ptr_q;
      case ({enq, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer storage: written at the slot after the current tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two entries are reset so instr/instr_pc read 0 out of reset.
      for (int i = 0; i < 2; i++) begin
        word_q[i] <= 32'd0;
        wpc_q[i]  <= 32'd0;
      end
    end else if (enq) begin
      word_q[wr_ptr] <= imem_rdata;
      wpc_q[wr_ptr]  <= pc_q;
    end
  end

  // Outputs: request rule, fetch address and halt flag from the current state.
  always_comb begin
    imem_addr = pc_q;
    imem_req  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_RUN:   imem_req = (count_q != 2'd2) || deq;
      S_DROP:  imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
`ifdef FETCH_HALT_EN
    halted = (state_q == S_HALT);
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks with literal expectations, then randomized
// traffic compared every cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h10;
`ifdef FETCH_HALT_EN
  localparam logic HALT_BUILD = 1'b1;
`else
  localparam logic HALT_BUILD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic        redirect_abs;
  logic [31:0] redirect_offset;
  logic [31:0] redirect_pc;
  logic        halted;

  int n_checks = 0;
  int n_err    = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_abs    (redirect_abs),
    .redirect_offset (redirect_offset),
    .redirect_pc     (redirect_pc),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory: contents and wait states ----------------
  bit halt_word_en = 1'b0;
  int fixed_wait   = 0;   // >=0: fixed wait count, <0: random per transfer
  int wcnt;
  int wtgt;

  function automatic logic [31:0] hash_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_word_en && a == 32'h5) return 32'hFC00_0000;
    return hash_word(a);
  endfunction

  assign imem_rdata = (halt_word_en && imem_addr == 32'h5) ? 32'hFC00_0000 : hash_word(imem_addr);
  assign imem_ack   = imem_req && (wcnt >= ((fixed_wait >= 0) ? fixed_wait : wtgt));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      wtgt <= 0;
    end else if (imem_req && imem_ack) begin
      wcnt <= 0;
      wtgt <= ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_drop;
  bit          m_halt;

  // Compare then advance the model once per cycle, on the falling edge.
  always @(negedge clk) begin : model
    bit          exp_valid, exp_req, mdeq, mxfer;
    logic [31:0] tgt;
    entry_t      e;
    if (!rst_n) begin
      m_q.delete();
      m_pc     = RST_PC;
      m_target = 32'd0;
      m_drop   = 1'b0;
      m_halt   = 1'b0;
    end else begin
      exp_valid = (m_q.size() != 0);
      mdeq      = exp_valid && instr_ready;
      exp_req   = !m_halt && (m_drop || m_q.size() < 2 || mdeq);
      check("m_valid", instr_valid, exp_valid);
      check("m_req", imem_req, exp_req);
      check("m_halted", halted, m_halt);
      if (exp_req) check("m_addr", imem_addr, m_pc);
      if (exp_valid) begin
        check("m_instr", instr, m_q[0].word);
        check("m_instr_pc", instr_pc, m_q[0].pc);
      end
      mxfer = exp_req && imem_ack;
      if (redirect) begin
        tgt = redirect_abs ? redirect_offset : redirect_pc + redirect_offset;
        m_q.delete();
        m_halt = 1'b0;
        if (exp_req && !imem_ack) begin
          m_drop   = 1'b1;
          m_target = tgt;
        end else begin
          m_drop = 1'b0;
          m_pc   = tgt;
        end
      end else begin
        if (mdeq) void'(m_q.pop_front());
        if (m_drop) begin
          if (mxfer) begin
            m_drop = 1'b0;
            m_pc   = m_target;
          end
        end else if (mxfer) begin
          e.word = mem_word(m_pc);
          e.pc   = m_pc;
          m_q.push_back(e);
          m_pc = m_pc + 32'd1;
`ifdef FETCH_HALT_EN
          if (e.word[31:26] == 6'd63) m_halt = 1'b1;
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic abs, input logic [31:0] off, input logic [31:0] rpc);
    redirect        = 1'b1;
    redirect_abs    = abs;
    redirect_offset = off;
    redirect_pc     = rpc;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    bit got;
    rst_n           = 1'b0;
    instr_ready     = 1'b1;
    redirect        = 1'b0;
    redirect_abs    = 1'b0;
    redirect_offset = 32'd0;
    redirect_pc     = 32'd0;
    fixed_wait      = 0;

    // Reset values.
    repeat (3) tick();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_addr", imem_addr, RST_PC);
    rst_n = 1'b1;

    // Zero-wait streaming from RESET_PC.
    @(negedge clk);
    check("a_req0", imem_req, 1'b1);
    check("a_addr0", imem_addr, 32'h10);
    check("a_valid0", instr_valid, 1'b0);
    @(negedge clk); check("a_pc1", instr_pc, 32'h10); check("a_addr1", imem_addr, 32'h11);
    @(negedge clk); check("a_pc2", instr_pc, 32'h11); check("a_addr2", imem_addr, 32'h12);
    @(negedge clk); check("a_pc3", instr_pc, 32'h12);

    // Consumer stall: two words buffered, no request, head held.
    tick();
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("b_valid", instr_valid, 1'b1);
    check("b_req", imem_req, 1'b0);
    check("b_head_pc", instr_pc, 32'h13);
    check("b_head_word", instr, hash_word(32'h13));
    tick();
    instr_ready = 1'b1;
    @(negedge clk); check("b_out0", instr_pc, 32'h13);
    @(negedge clk); check("b_out1", instr_pc, 32'h14);
    @(negedge clk); check("b_out2", instr_pc, 32'h15);

    // 3-wait memory, PC-relative redirect during the wait.
    fixed_wait = 3;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req && !imem_ack && wcnt == 1) begin
        got = 1'b1;
        break;
      end
    end
    check("c_align", got, 1'b1);
    pulse_redirect(1'b0, 32'h8, 32'h20);
    @(negedge clk);
    check("c_valid_after", instr_valid, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_ack) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("c_drop_ack", got, 1'b1);
    @(negedge clk);
    check("c_addr", imem_addr, 32'h28);
    check("c_req", imem_req, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("c_first_seen", got, 1'b1);
    check("c_first_pc", instr_pc, 32'h28);

    // Absolute redirect coinciding with an ack and a dequeue.
    fixed_wait = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid && imem_req && imem_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("d_align", got, 1'b1);
    pulse_redirect(1'b1, 32'h100, 32'h0);
    @(negedge clk);
    check("d_valid", instr_valid, 1'b0);
    check("d_addr", imem_addr, 32'h100);
    @(negedge clk);
    check("d_pc", instr_pc, 32'h100);
    check("d_word", instr, hash_word(32'h100));

    // PC wrap at 32'hFFFF_FFFF.
    tick();
    pulse_redirect(1'b1, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk); check("e_addr_max", imem_addr, 32'hFFFF_FFFF);
    @(negedge clk); check("e_pc_max", instr_pc, 32'hFFFF_FFFF); check("e_addr_wrap", imem_addr, 32'h0);

    // Halt word at 0x5.
    tick();
    halt_word_en = 1'b1;
    pulse_redirect(1'b1, 32'h3, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 32'h5) begin
        got = 1'b1;
        break;
      end
    end
    check("f_halt_seen", got, 1'b1);
    check("f_halt_word", instr, 32'hFC00_0000);
    check("f_halted", halted, HALT_BUILD);
`ifdef FETCH_HALT_EN
    check("f_req_off", imem_req, 1'b0);
    repeat (3) @(negedge clk);
    check("f_req_still_off", imem_req, 1'b0);
    check("f_drained", instr_valid, 1'b0);
    check("f_halted_hold", halted, 1'b1);
`endif
    tick();
    halt_word_en = 1'b0;
    pulse_redirect(1'b1, 32'h0, 32'h0);
    @(negedge clk);
    check("f_resume_halted", halted, 1'b0);
    check("f_resume_addr", imem_addr, 32'h0);
    check("f_resume_req", imem_req, 1'b1);

    // Reset asserted in the middle of a waited transfer.
    tick();
    fixed_wait = 2;
    tick();
    tick();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("g_rst_valid", instr_valid, 1'b0);
    check("g_rst_addr", imem_addr, RST_PC);
    tick();
    rst_n = 1'b1;
    fixed_wait = 0;
    @(negedge clk); check("g_addr", imem_addr, 32'h10); check("g_req", imem_req, 1'b1);
    @(negedge clk); check("g_pc", instr_pc, 32'h10);

    // Randomized traffic against the model.
    fixed_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect        = 1'b1;
        redirect_abs    = 1'($urandom_range(0, 1));
        redirect_pc     = $urandom;
        redirect_offset = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      end else begin
        redirect = 1'b0;
      end
    end
    tick();
    redirect = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
